// File: rtl/pg_lane_fifo.sv
// Multi-lane elastic buffer: LANES independent FIFOs, each WIDTH bits by DEPTH entries,
// with per-lane valid/ready on both sides, occupancy reporting and synchronous flush.
module pg_lane_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LANES = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_valid,
    output logic [LANES-1:0]       in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             push, pop;

        // in_ready looks only at occupancy, so a full lane refuses a push even during a pop
        assign in_ready[g]                  = (cnt_q < FULL);
        assign out_valid[g]                 = (cnt_q != '0);
        assign out_data[g*WIDTH +: WIDTH]   = mem_q[rd_ptr_q];
        assign count[g*CW +: CW]            = cnt_q;
        assign push                         = in_valid[g] & in_ready[g];
        assign pop                          = out_valid[g] & out_ready[g];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + CW'(1);
                    2'b01:   cnt_d = cnt_q - CW'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage is zeroed by reset but deliberately left intact by flush
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (push && !flush) begin
                mem_q[wr_ptr_q] <= in_data[g*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: doc/pg_lane_fifo.md
# pg_lane_fifo

Parametrised multi-lane elastic buffer: LANES independent channels, each WIDTH bits wide and DEPTH entries deep, with per-lane valid/ready handshakes on both sides. It is the buffered successor to the pass-through leaf used in the elaboration tests. It generalises width, lane count (via generate) and depth, and adds real storage, flow control, occupancy reporting and a synchronous flush. It sits between a producer and a consumer group and decouples them lane by lane.

## Interface
- WIDTH, 8, data bits per lane (>= 1)
- DEPTH, 4, entries per lane (>= 1; any integer, not restricted to powers of two)
- LANES, 2, number of independent lanes (>= 1)
- CW, $clog2(DEPTH+1), derived local parameter: occupancy counter width

- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all lanes
- in_data  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  LANES  per-lane push request
- in_ready  output  LANES  per-lane space available
- out_data  output  LANES*WIDTH  head entry of each lane, same packing as in_data
- out_valid  output  LANES  per-lane data available
- out_ready  input  LANES  per-lane pop acknowledge
- count  output  LANES*CW  per-lane occupancy; lane i occupies bits [i*CW +: CW]

## Operation
- Each lane is an independent FIFO instance built in a generate loop. No lane's state depends on another lane's inputs.
- Push (lane i): in_valid[i] && in_ready[i] at a rising edge. in_data slice is written at the write pointer, and the write pointer advances.
- Pop (lane i): out_valid[i] && out_ready[i] at a rising edge. The read pointer advances.
- Pointers wrap from DEPTH-1 to 0. Explicit compare is used, not modulo-2^n.
- in_ready[i] = (count_i < DEPTH). It does not depend on out_ready, so a full lane refuses a push even when a pop occurs in the same cycle.
- out_valid[i] = (count_i != 0).
- out_data slice = storage[rd_ptr]. It is a combinational read of registered storage and is stable while out_valid is high and no pop occurs.
- Count update per lane:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Simultaneous push and pop on a non-empty, non-full lane: both complete and the count is unchanged.
- Push and pop in the same cycle on an empty lane is impossible, because out_valid = 0.
- Push to a full lane is ignored because in_ready = 0. Data in the lane is untouched.
- Pop when out_valid = 0 is ignored.
- Flush: on any edge with flush = 1, every lane's pointers and count go to 0.
  - Pushes and pops presented in that cycle are discarded.
  - Storage contents are not cleared.
- Arithmetic: count is CW bits and never exceeds DEPTH. Pointers are $clog2(DEPTH) bits, with a minimum of 1.

## Timing
- Reset (rst_n low, asynchronous assert; deassert synchronised by the integrating block):
  - count = 0, out_valid = 0, in_ready = all 1s
  - pointers = 0, storage = 0, so out_data = 0
- Reset asserted mid-operation: all lanes return to the reset state immediately, without waiting for a clock. In-flight data is lost.
- Latency: a word pushed at edge N into an empty lane gives out_valid = 1 and out_data = that word after edge N. It can be popped at edge N+1. There is no same-cycle bypass.
- Full throughput: one push and one pop per lane per cycle when 0 < count < DEPTH.
- in_ready deasserts in the cycle after the push that fills the lane. It reasserts in the cycle after the first pop from a full lane.
- Flush takes effect at the edge where it is sampled. The next cycle shows count = 0, out_valid = 0, in_ready = 1 on all lanes.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with random inputs -> count = 0, out_valid = 0, in_ready = 2'b11, out_data = 0. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- Fill/drain, WIDTH = 8, DEPTH = 4, lane 0: push 0x11, 0x22, 0x33, 0x44 with out_ready = 0 -> count0 steps 1..4 and in_ready[0] = 0. A 5th push of 0x55 is dropped. Drain -> out_data reads 0x11, 0x22, 0x33, 0x44 in order, then out_valid[0] = 0.
- Wrap-around, DEPTH = 3: stream 10 words with in_valid and out_ready held high after the first push -> count stays 1, output order equals input order, pointers wrap 2 -> 0 three times.
- Full-lane simultaneous push and pop: lane full with count = 4, push 0xAA and pop the same cycle -> pop completes, push is rejected, count = 3, 0xAA is never output.
- Lane independence, LANES = 2: lane 1 is full and stalled while lane 0 streams 0x01..0x08 -> lane 0 throughput is 1 word per cycle and lane 1 count stays 4.
- Flush: both lanes hold 2 entries, assert flush with simultaneous push on lane 0 -> next cycle count = 0 on both lanes, out_valid = 0, and the pushed word is never output.
